// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: detects D-stage source-operand hazards against
// in-flight E/M results, interlocks MDU instructions behind a busy multiplier/
// divider, and keeps a saturating count of stalled cycles.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_mdu,
  input  logic        E_mdu_start,
  input  logic        E_mdu_div,
  output logic        PC_WrEn,
  output logic        FD_WrEn,
  output logic        DE_flush,
  output logic        EM_WrEn,
  output logic        MW_WrEn,
  output logic        stall,
  output logic        mdu_busy,
  output logic [3:0]  mdu_cnt,
  output logic [15:0] stall_cycles
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

  mdu_state_t  state_r;
  mdu_state_t  state_next_s;
  logic [3:0]  mdu_cnt_r;
  logic [3:0]  mdu_cnt_next_s;
  logic        mdu_busy_r;
  logic [15:0] stall_cycles_r;
  logic        stall_rs_s;
  logic        stall_rt_s;
  logic        stall_mdu_s;
  logic        stall_s;

  // A source register stalls when it is used in time and an older instruction
  // writing it will not have its result ready early enough. Register 0 never
  // carries a dependency, which also masks E_A3/M_A3 == 0 ("no destination").
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew
  );
    return (tuse != 2'd3) && (src != 5'd0) &&
           (((e_a3 == src) && (e_tnew > tuse)) ||
            ((m_a3 == src) && (m_tnew > tuse)));
  endfunction

  // Combinational stall decision for the current D-stage instruction.
  always_comb begin
    stall_rs_s  = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    stall_rt_s  = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
    stall_mdu_s = D_is_mdu && (mdu_busy_r || E_mdu_start);
    stall_s     = stall_rs_s || stall_rt_s || stall_mdu_s;
  end

  // MDU next-state: a start is accepted only when idle; busy counts down to 0.
  always_comb begin
    state_next_s   = state_r;
    mdu_cnt_next_s = mdu_cnt_r;
    case (state_r)
      IDLE: begin
        if (E_mdu_start) begin
          mdu_cnt_next_s = E_mdu_div ? DIV_LOAD : MULT_LOAD;
          state_next_s   = (mdu_cnt_next_s != 4'd0) ? BUSY : IDLE;
        end else begin
          mdu_cnt_next_s = 4'd0;
          state_next_s   = IDLE;
        end
      end
      BUSY: begin
        mdu_cnt_next_s = mdu_cnt_r - 4'd1;
        state_next_s   = (mdu_cnt_r == 4'd1) ? IDLE : BUSY;
      end
      default: begin
        mdu_cnt_next_s = 4'd0;
        state_next_s   = IDLE;
      end
    endcase
  end

  // MDU state, count and busy flag registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mdu_cnt_r  <= 4'd0;
      mdu_busy_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      mdu_cnt_r  <= mdu_cnt_next_s;
      mdu_busy_r <= (mdu_cnt_next_s != 4'd0);
    end
  end

  // Saturating count of cycles in which the front end was stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= 16'd0;
    end else if (stall_s && (stall_cycles_r != 16'hFFFF)) begin
      stall_cycles_r <= stall_cycles_r + 16'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall        = stall_s;
  assign PC_WrEn      = ~stall_s;
  assign FD_WrEn      = ~stall_s;
  assign DE_flush     = stall_s;
  assign EM_WrEn      = 1'b1;
  assign MW_WrEn      = 1'b1;
  assign mdu_busy     = mdu_busy_r;
  assign mdu_cnt      = mdu_cnt_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have D_rs, D_rt  input  5 each  D-stage source register numbers.
REQ-006 SHALL have D_Tuse_rs, D_Tuse_rt  input  2 each  cycles until operand needed; 3 = operand unused.
REQ-007 SHALL have E_A3, M_A3  input  5 each  destination register of E/M stage instruction; 0 = none.
REQ-008 SHALL have E_Tnew, M_Tnew  input  2 each  remaining cycles until result available in that stage.
REQ-009 SHALL have D_is_mdu  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have E_mdu_start  input  1  E-stage mult/div issuing this cycle; E_mdu_div  input  1  1 = div, 0 = mult.
REQ-011 SHALL have outputs PC_WrEn, FD_WrEn, DE_flush, EM_WrEn, MW_WrEn  1 each  pipeline register controls.
REQ-012 SHALL have stall  output  1; mdu_busy  output  1; mdu_cnt  output  4  remaining busy cycles; stall_cycles  output  16  performance count.

Function
REQ-013 SHALL compute stall_rs = (D_Tuse_rs!=3) && (D_rs!=0) && ((E_A3==D_rs && E_Tnew>D_Tuse_rs) || (M_A3==D_rs && M_Tnew>D_Tuse_rs)), combinationally.
REQ-014 SHALL compute stall_rt identically using D_rt/D_Tuse_rt.
REQ-015 SHALL compute stall_mdu = D_is_mdu && (mdu_busy || E_mdu_start).
REQ-016 SHALL drive stall = stall_rs | stall_rt | stall_mdu, combinationally, same cycle as inputs.
REQ-017 SHALL drive PC_WrEn = FD_WrEn = ~stall, DE_flush = stall, EM_WrEn = MW_WrEn = 1.
REQ-018 SHALL implement MDU FSM states IDLE (mdu_cnt==0) and BUSY (mdu_cnt!=0); mdu_busy = (mdu_cnt!=0), registered.
REQ-019 SHALL, in IDLE with E_mdu_start=1, load mdu_cnt with DIV_CYCLES if E_mdu_div else MULT_CYCLES at the clock edge.
REQ-020 SHALL, in BUSY, decrement mdu_cnt by 1 per clock; transition to IDLE when mdu_cnt reaches 0; mdu_busy therefore high exactly N cycles after the start edge.
REQ-021 SHALL ignore E_mdu_start while BUSY (count not reloaded, not extended).
REQ-022 SHALL treat parameter values 0 as "no busy" (mdu_cnt stays 0); values above 15 are illegal configurations.
REQ-023 SHALL increment stall_cycles by 1 at each edge where stall=1, saturating at 16'hFFFF (no wrap).
REQ-024 SHALL ignore Tnew comparisons when E_A3 or M_A3 equals 0 (covered by D_rs/D_rt!=0 check).

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set mdu_cnt=0, mdu_busy=0, stall_cycles=0, overriding E_mdu_start in the same cycle.
REQ-026 SHALL abort an in-progress MDU operation on reset mid-count (returns to IDLE next cycle).
REQ-027 SHALL keep combinational outputs a function of current inputs and registered state during reset (stall from hazards still visible; stall_cycles held at 0).

Verification
REQ-028 SHALL cover: E_A3=8, E_Tnew=2, D_rs=8, D_Tuse_rs=1 -> stall=1, PC_WrEn=0, DE_flush=1; change E_Tnew=1 -> stall=0.
REQ-029 SHALL cover: D_rs=0, E_A3=0, E_Tnew=2, D_Tuse_rs=0 -> stall=0.
REQ-030 SHALL cover: E_mdu_start=1, E_mdu_div=0 one cycle -> mdu_busy high exactly 5 cycles, mdu_cnt 5,4,3,2,1 then 0; D_is_mdu=1 stalls during those cycles and the start cycle.
REQ-031 SHALL cover: div start, second E_mdu_start at cnt=6 -> count continues 5..1, total busy 10 cycles.
REQ-032 SHALL cover: div start, reset asserted at cnt=7 -> mdu_cnt=0, mdu_busy=0, stall_cycles=0 next cycle.
REQ-033 SHALL cover: stall held 1 for 70000 cycles -> stall_cycles reads 16'hFFFF and stays there.
